// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clk_div_bank programmable divider bank.
package clk_div_pkg;

    localparam int DEF_DIV_C = 256;
    localparam int DEF_HI_C  = 128;

    // Channel-select width; a single channel still gets a 1-bit select port.
    function automatic int calc_ch_w(input int nch);
        if (nch > 1) begin
            return $clog2(nch);
        end else begin
            return 1;
        end
    endfunction

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        if (d < 16'd2) begin
            return 16'd2;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active div/hi registers and a one-deep
// pending shadow that is applied at the period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 10,
    parameter int DEF_DIV = DEF_DIV_C,
    parameter int DEF_HI  = DEF_HI_C
)(
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_hi,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r, div_r, hi_r, pdiv_r, phi_r;
    logic [DIV_W-1:0] cnt_s, div_s, hi_s, pdiv_s, phi_s;
    logic             pend_r, run_r, clk_r, tick_r;
    logic             pend_s, clk_s, tick_s, wrap_s;

    // run_r distinguishes the first enabled cycle, which holds cnt at 0.
    assign wrap_s = sync || (cnt_r >= (div_r - DIV_W'(1)));

    // Next-state: outputs are computed from the next cnt/div/hi so that the
    // registered clk_out/tick line up with cnt with zero latency.
    always_comb begin
        cnt_s  = cnt_r;
        div_s  = div_r;
        hi_s   = hi_r;
        pdiv_s = pdiv_r;
        phi_s  = phi_r;
        pend_s = pend_r;
        clk_s  = 1'b0;
        tick_s = 1'b0;
        if (!en) begin
            cnt_s  = {DIV_W{1'b0}};
            pend_s = 1'b0;
            if (wr) begin
                div_s = wr_div;
                hi_s  = wr_hi;
            end else if (pend_r) begin
                div_s = pdiv_r;
                hi_s  = phi_r;
            end else begin
                div_s = div_r;
            end
        end else begin
            if (run_r && wrap_s) begin
                cnt_s = {DIV_W{1'b0}};
                if (pend_r) begin
                    div_s  = pdiv_r;
                    hi_s   = phi_r;
                    pend_s = 1'b0;
                end else begin
                    pend_s = 1'b0;
                end
            end else if (!run_r) begin
                cnt_s = {DIV_W{1'b0}};
            end else begin
                cnt_s = cnt_r + DIV_W'(1);
            end
            // A write in the wrap cycle lands in the shadow: no same-cycle bypass.
            if (wr) begin
                pend_s = 1'b1;
                pdiv_s = wr_div;
                phi_s  = wr_hi;
            end else begin
                pdiv_s = pdiv_r;
            end
            clk_s  = (cnt_s < hi_s);
            tick_s = (cnt_s == (div_s - DIV_W'(1)));
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {DIV_W{1'b0}};
            div_r  <= DIV_W'(DEF_DIV);
            hi_r   <= DIV_W'(DEF_HI);
            pdiv_r <= DIV_W'(DEF_DIV);
            phi_r  <= DIV_W'(DEF_HI);
            pend_r <= 1'b0;
            run_r  <= 1'b0;
            clk_r  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            div_r  <= div_s;
            hi_r   <= hi_s;
            pdiv_r <= pdiv_s;
            phi_r  <= phi_s;
            pend_r <= pend_s;
            run_r  <= en;
            clk_r  <= clk_s;
            tick_r <= tick_s;
        end
    end

    assign pending = pend_r;
    assign clk_out = clk_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH runtime-programmable integer clock dividers off clk_in.
// Optional CLK_DIV_BANK_SYNC_EN adds sync_pulse to phase-align all channels.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH     = 5,
    parameter int DIV_W   = 10,
    parameter int DEF_DIV = DEF_DIV_C,
    parameter int DEF_HI  = DEF_HI_C,
    parameter int CH_W    = calc_ch_w(NCH)
)(
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_hi,
    input  logic [NCH-1:0]   ch_en,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
`ifdef CLK_DIV_BANK_SYNC_EN
    ,
    input  logic             sync_pulse
`endif
);

    logic [NCH-1:0]   pend_s;
    logic [NCH-1:0]   wr_s;
    logic [DIV_W-1:0] div_cl_s;
    logic             ready_s;
    logic             sync_s;

`ifdef CLK_DIV_BANK_SYNC_EN
    assign sync_s = sync_pulse;
`else
    assign sync_s = 1'b0;
`endif

    assign div_cl_s = DIV_W'(clamp_div(16'(cfg_div)));

    // Out-of-range channel numbers are always ready and simply dropped.
    always_comb begin
        ready_s = 1'b1;
        if (32'(cfg_ch) < NCH) begin
            ready_s = !pend_s[cfg_ch];
        end else begin
            ready_s = 1'b1;
        end
    end

    assign cfg_ready = ready_s;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr_s[g] = cfg_valid && ready_s && (32'(cfg_ch) == g);

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HI  (DEF_HI)
        ) u_chan (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (ch_en[g]),
            .sync    (sync_s),
            .wr      (wr_s[g]),
            .wr_div  (div_cl_s),
            .wr_hi   (cfg_hi),
            .pending (pend_s[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with hand-computed expectations.
module tb_clk_div_bank;

    localparam int NCH   = 5;
    localparam int DIV_W = 10;
    localparam int CH_W  = 3;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_hi;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic             sync_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt [NCH];
    int tk_cnt [NCH];

    clk_div_bank #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_hi    (cfg_hi),
        .ch_en     (ch_en),
        .clk_out   (clk_out),
        .tick      (tick)
`ifdef CLK_DIV_BANK_SYNC_EN
        ,
        .sync_pulse(sync_pulse)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < NCH; c++) begin
            hi_cnt[c] = 0;
            tk_cnt[c] = 0;
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCH; c++) begin
                hi_cnt[c] += int'(clk_out[c]);
                tk_cnt[c] += int'(tick[c]);
            end
            cyc(1);
        end
    endtask

    task automatic cfg_set(input int ch, input int dv, input int hv);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_hi    = DIV_W'(hv);
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_en      = 5'b00000;
        cfg_valid  = 1'b0;
        cfg_ch     = 3'd0;
        cfg_div    = 10'd0;
        cfg_hi     = 10'd0;
        sync_pulse = 1'b0;

        #3;
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        cyc(2);

        // Defaults: period 256, 128 high, all channels in phase.
        rst_n = 1'b1;
        ch_en = 5'b11111;
        cyc(1);
        chk("def_cnt0_clk", 32'(clk_out), 32'h1f);
        chk("def_cnt0_tick", 32'(tick), 32'h0);
        cyc(127);
        chk("def_cnt127_clk", 32'(clk_out), 32'h1f);
        cyc(1);
        chk("def_cnt128_clk", 32'(clk_out), 32'h0);
        cyc(127);
        chk("def_cnt255_tick", 32'(tick), 32'h1f);
        cyc(1);
        chk("def_wrap_tick", 32'(tick), 32'h0);
        chk("def_wrap_clk", 32'(clk_out), 32'h1f);

        // Writes at cnt=4..7; all pend until the common wrap.
        cyc(4);
        cfg_set(0, 10, 3);
        #1;
        chk("wr0_ready", 32'(cfg_ready), 32'h1);
        cyc(1);
        cfg_set(0, 6, 2);
        #1;
        chk("wr0_stall", 32'(cfg_ready), 32'h0);
        cfg_set(1, 1, 1);
        #1;
        chk("wr1_ready", 32'(cfg_ready), 32'h1);
        cyc(1);
        cfg_set(3, 4, 0);
        cyc(1);
        cfg_set(4, 5, 5);
        cyc(1);
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        #1;
        chk("pend_old_clk", 32'(clk_out), 32'h1f);
        chk("pend_ready0", 32'(cfg_ready), 32'h0);
        cyc(247);
        chk("pend_cnt255_tick", 32'(tick), 32'h1f);
        chk("pend_cnt255_ready", 32'(cfg_ready), 32'h0);
        cyc(1);
        chk("new_w0_ready", 32'(cfg_ready), 32'h1);
        chk("new_w0_clk", 32'(clk_out), 32'h17);
        chk("new_w0_tick", 32'(tick), 32'h0);
        measure(20);
        chk("ch0_highs", 32'(hi_cnt[0]), 32'd6);
        chk("ch0_ticks", 32'(tk_cnt[0]), 32'd2);
        chk("ch1_clamp_highs", 32'(hi_cnt[1]), 32'd10);
        chk("ch1_clamp_ticks", 32'(tk_cnt[1]), 32'd10);
        chk("ch2_highs", 32'(hi_cnt[2]), 32'd20);
        chk("ch2_ticks", 32'(tk_cnt[2]), 32'd0);
        chk("ch3_hi0_highs", 32'(hi_cnt[3]), 32'd0);
        chk("ch3_hi0_ticks", 32'(tk_cnt[3]), 32'd5);
        chk("ch4_hidiv_highs", 32'(hi_cnt[4]), 32'd20);
        chk("ch4_hidiv_ticks", 32'(tk_cnt[4]), 32'd4);

        // Disable ch2 mid-period, reprogram while disabled, re-enable.
        ch_en = 5'b11011;
        cyc(1);
        chk("dis_clk2", 32'(clk_out[2]), 32'h0);
        chk("dis_tick2", 32'(tick[2]), 32'h0);
        cfg_set(2, 4, 2);
        #1;
        chk("dis_wr_ready", 32'(cfg_ready), 32'h1);
        cyc(1);
        cfg_valid = 1'b0;
        chk("dis_hold_clk2", 32'(clk_out[2]), 32'h0);
        ch_en = 5'b11111;
        cyc(1);
        chk("reen_clk2", 32'(clk_out[2]), 32'h1);
        chk("reen_tick2", 32'(tick[2]), 32'h0);
        measure(8);
        chk("reen_highs2", 32'(hi_cnt[2]), 32'd4);
        chk("reen_ticks2", 32'(tk_cnt[2]), 32'd2);

        // Out-of-range channel is accepted and dropped.
        cfg_set(5, 3, 1);
        #1;
        chk("oor_ready", 32'(cfg_ready), 32'h1);
        cyc(1);
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;

`ifdef CLK_DIV_BANK_SYNC_EN
        sync_pulse = 1'b1;
        cyc(1);
        sync_pulse = 1'b0;
        chk("sync_clk", 32'(clk_out), 32'h17);
        chk("sync_tick", 32'(tick), 32'h0);
        cyc(1);
        chk("sync_next_clk", 32'(clk_out), 32'h15);
        chk("sync_next_tick", 32'(tick), 32'h02);
`endif

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk", 32'(clk_out), 32'h0);
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_ready", 32'(cfg_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
